// File: rtl/udiv64_host_pkg.sv
// Shared constants for the udiv64 register-window divider and its host initiator.
// Latency: n/a (constants, types and a pure chunk-select helper only).
// Backpressure: n/a.
package udiv64_host_pkg;

    // Chunk locations on in_loc / out_loc.
    localparam logic [31:0] LOC_0 = 32'd0;
    localparam logic [31:0] LOC_1 = 32'd1;
    localparam logic [31:0] LOC_2 = 32'd2;
    localparam logic [31:0] LOC_3 = 32'd3;
    localparam logic [31:0] LOC_4 = 32'd4;
    localparam logic [31:0] LOC_5 = 32'd5;
    localparam logic [31:0] LOC_6 = 32'd6;
    localparam logic [31:0] LOC_7 = 32'd7;

    // Peripheral state codes as they appear on state_reg.
    localparam logic [31:0] PST_IDLE  = 32'd0;
    localparam logic [31:0] PST_DIV1  = 32'd1;
    localparam logic [31:0] PST_DIV2  = 32'd2;
    localparam logic [31:0] PST_FINAL = 32'd3;

    // Control register values.
    localparam logic [31:0] CTRL_RUN  = 32'd1;
    localparam logic [31:0] CTRL_STOP = 32'd0;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_DIV1  = 2'd1,
        P_DIV2  = 2'd2,
        P_FINAL = 2'd3
    } pst_t;

    // Operand chunk for load index 0..3: dividend lo/hi, divisor lo/hi.
    function automatic logic [31:0] load_chunk(input logic [63:0] dvd,
                                               input logic [63:0] dvs,
                                               input logic [1:0]  idx);
        logic [31:0] v;
        case (idx)
            2'd0:    v = dvd[31:0];
            2'd1:    v = dvd[63:32];
            2'd2:    v = dvs[31:0];
            default: v = dvs[63:32];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/udiv64.sv
// Register-window 64-bit unsigned divider peripheral (restoring, one DIV1/DIV2 pair per bit).
// Latency: 128 cycles of DIV1/DIV2 after ctrl_reg=1, then FINAL; readback 1 cycle after in_loc.
// Backpressure: none; the initiator paces everything through in_loc and ctrl_reg.
// Ports: clk, reset (async active-low); in_loc/in_val chunk window; ctrl_reg run/stop;
//        out_loc/out_val readback; state_reg = peripheral state delayed by one cycle.
module udiv64
    import udiv64_host_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_loc,
    input  logic [31:0] in_val,
    input  logic [31:0] ctrl_reg,
    output logic [31:0] out_loc,
    output logic [31:0] out_val,
    output logic [31:0] state_reg
);

    pst_t        r_st;
    logic [5:0]  r_cnt;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_q;
    logic [64:0] r_r;      // partial remainder needs 65 bits after the shift
    logic [31:0] r_out_loc;
    logic [31:0] r_out_val;
    logic [31:0] r_state_reg;

    assign out_loc   = r_out_loc;
    assign out_val   = r_out_val;
    assign state_reg = r_state_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st        <= P_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_out_loc   <= '0;
            r_out_val   <= '0;
            r_state_reg <= '0;
        end else begin
            r_state_reg <= {30'd0, r_st};
            r_out_loc   <= LOC_0;
            r_out_val   <= '0;
            if (ctrl_reg != CTRL_RUN) begin
                r_st <= P_IDLE;
                if (r_st == P_IDLE) begin
                    case (in_loc)
                        LOC_1:   r_a[31:0]  <= in_val;
                        LOC_2:   r_a[63:32] <= in_val;
                        LOC_3:   r_b[31:0]  <= in_val;
                        LOC_4:   r_b[63:32] <= in_val;
                        default: ;
                    endcase
                end
            end else begin
                case (r_st)
                    P_IDLE: begin
                        r_q   <= r_a;
                        r_r   <= '0;
                        r_cnt <= '0;
                        r_st  <= P_DIV1;
                    end
                    P_DIV1: begin
                        r_r  <= {r_r[63:0], r_q[63]};
                        r_q  <= {r_q[62:0], 1'b0};
                        r_st <= P_DIV2;
                    end
                    P_DIV2: begin
                        // A zero divisor always subtracts: quotient all ones, remainder = dividend.
                        if (r_r >= {1'b0, r_b}) begin
                            r_r    <= r_r - {1'b0, r_b};
                            r_q[0] <= 1'b1;
                        end
                        r_cnt <= r_cnt + 6'd1;
                        r_st  <= (r_cnt == 6'd63) ? P_FINAL : P_DIV1;
                    end
                    default: begin
                        case (in_loc)
                            LOC_4: begin r_out_loc <= LOC_1; r_out_val <= r_q[31:0];  end
                            LOC_5: begin r_out_loc <= LOC_2; r_out_val <= r_q[63:32]; end
                            LOC_6: begin r_out_loc <= LOC_3; r_out_val <= r_r[31:0];  end
                            LOC_7: begin r_out_loc <= LOC_4; r_out_val <= r_r[63:32]; end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/udiv64_host.sv
// Host initiator: loads operands into a udiv64 peripheral, runs it, polls, reads back results.
// Latency: fixed accept-to-resp_valid (load 4 + start 1 + peripheral run + readback 5 + clear).
// Backpressure: req_ready only in IDLE (one op in flight); resp_valid holds until resp_ready.
// Ports: clk, reset (async active-low); req_valid/req_ready/dividend/divisor request;
//        resp_valid/resp_ready/quotient/remainder/dz/err response;
//        in_loc/in_val/ctrl_reg to peripheral; out_loc/out_val/state_reg from peripheral.
module udiv64_host
    import udiv64_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic        dz,
    output logic        err,
    output logic [31:0] in_loc,
    output logic [31:0] in_val,
    output logic [31:0] ctrl_reg,
    input  logic [31:0] out_loc,
    input  logic [31:0] out_val,
    input  logic [31:0] state_reg
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_CLEAR, S_RESP
    } host_st_t;

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    host_st_t     r_st;
    logic [1:0]   r_idx;     // operand chunk currently on in_loc during LOAD
    logic [2:0]   r_step;    // READ step: 0 drives only, 1..4 capture chunk step-1
    logic [CW-1:0] r_cnt;
    logic [63:0]  r_dvd;
    logic [63:0]  r_dvs;
    logic [127:0] r_res;     // {r hi, r lo, q hi, q lo}
    logic         r_req_ready;
    logic         r_resp_valid;
    logic         r_dz;
    logic         r_err;
    logic [31:0]  r_in_loc;
    logic [31:0]  r_in_val;
    logic [31:0]  r_ctrl;

    logic [1:0]   w_cap_idx;
    logic [31:0]  w_exp_loc;

    // Readback of in_loc=4+k arrives as out_loc=1+k one cycle later.
    assign w_cap_idx = r_step[1:0] - 2'd1;
    assign w_exp_loc = LOC_1 + {30'd0, w_cap_idx};

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign quotient   = r_res[63:0];
    assign remainder  = r_res[127:64];
    assign dz         = r_dz;
    assign err        = r_err;
    assign in_loc     = r_in_loc;
    assign in_val     = r_in_val;
    assign ctrl_reg   = r_ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st         <= S_IDLE;
            r_idx        <= '0;
            r_step       <= '0;
            r_cnt        <= '0;
            r_dvd        <= '0;
            r_dvs        <= '0;
            r_res        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_dz         <= 1'b0;
            r_err        <= 1'b0;
            r_in_loc     <= LOC_0;
            r_in_val     <= '0;
            r_ctrl       <= CTRL_STOP;
        end else begin
            case (r_st)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    r_in_loc    <= LOC_0;
                    r_ctrl      <= CTRL_STOP;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_dvd       <= dividend;
                        r_dvs       <= divisor;
                        r_dz        <= (divisor == 64'd0);
                        r_err       <= 1'b0;
                        r_res       <= '0;
                        r_idx       <= 2'd0;
                        r_in_loc    <= LOC_1;
                        r_in_val    <= dividend[31:0];
                        r_st        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_idx == 2'd3) begin
                        r_in_loc <= LOC_0;
                        r_in_val <= '0;
                        r_ctrl   <= CTRL_RUN;
                        r_cnt    <= '0;
                        r_st     <= S_START;
                    end else begin
                        r_idx    <= r_idx + 2'd1;
                        r_in_loc <= LOC_2 + {30'd0, r_idx};
                        r_in_val <= load_chunk(r_dvd, r_dvs, r_idx + 2'd1);
                    end
                end
                S_START: begin
                    r_cnt <= '0;
                    r_st  <= S_WAIT;
                end
                S_WAIT: begin
                    if (state_reg == PST_FINAL) begin
                        r_step   <= 3'd0;
                        r_in_loc <= LOC_4;
                        r_st     <= S_READ;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err  <= 1'b1;
                        r_res  <= '0;
                        r_ctrl <= CTRL_STOP;
                        r_st   <= S_CLEAR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (r_step != 3'd0) begin
                        case (w_cap_idx)
                            2'd0:    r_res[31:0]   <= out_val;
                            2'd1:    r_res[63:32]  <= out_val;
                            2'd2:    r_res[95:64]  <= out_val;
                            default: r_res[127:96] <= out_val;
                        endcase
                        if (out_loc != w_exp_loc) begin
                            r_err <= 1'b1;
                        end
                    end
                    if (r_step == 3'd4) begin
                        r_in_loc <= LOC_0;
                        r_ctrl   <= CTRL_STOP;
                        r_st     <= S_CLEAR;
                    end else begin
                        r_step   <= r_step + 3'd1;
                        r_in_loc <= (r_step < 3'd3) ? (LOC_5 + {29'd0, r_step}) : LOC_0;
                    end
                end
                S_CLEAR: begin
                    r_in_loc <= LOC_0;
                    r_ctrl   <= CTRL_STOP;
                    if (state_reg == PST_IDLE) begin
                        r_resp_valid <= 1'b1;
                        r_st         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_st         <= S_IDLE;
                    end
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udiv64_host.sv
module tb_udiv64_host;
    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        dz;
    logic        err;
    logic [31:0] in_loc;
    logic [31:0] in_val;
    logic [31:0] ctrl_reg;
    logic [31:0] out_loc;
    logic [31:0] out_val;
    logic [31:0] p_state;
    logic [31:0] state_mux;
    logic        use_stub = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat_ref  = -1;

    always #5 clk = ~clk;

    // Stub: stuck in DIV1 while running, back to IDLE when stopped.
    assign state_mux = use_stub ? ((ctrl_reg == 32'd1) ? 32'd1 : 32'd0) : p_state;

    udiv64_host #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .dividend(dividend), .divisor(divisor),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .quotient(quotient), .remainder(remainder), .dz(dz), .err(err),
        .in_loc(in_loc), .in_val(in_val), .ctrl_reg(ctrl_reg),
        .out_loc(out_loc), .out_val(out_val), .state_reg(state_mux)
    );

    udiv64 periph (
        .clk(clk), .reset(rst_n),
        .in_loc(in_loc), .in_val(in_val), .ctrl_reg(ctrl_reg),
        .out_loc(out_loc), .out_val(out_val), .state_reg(p_state)
    );

    // Reference: {quotient, remainder, dz} from plain unsigned arithmetic.
    function automatic logic [128:0] ref_div(input logic [63:0] a, input logic [63:0] b);
        if (b == 64'd0) return {64'hFFFF_FFFF_FFFF_FFFF, a, 1'b1};
        return {a / b, a % b, 1'b0};
    endfunction

    task automatic send_req(input logic [63:0] a, input logic [63:0] b, input bit hold);
        int n = 0;
        dividend  = a;
        divisor   = b;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL accept_wait req_ready=%0b required 1 within 50 cycles", req_ready);
            n_fail++;
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 2 * TMO) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (resp_valid !== 1'b1) begin
            $display("FAIL resp_wait resp_valid=%0b required 1 within %0d cycles", resp_valid, 2 * TMO);
            n_fail++;
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, resp_valid, dz, err, quotient, remainder, in_loc, in_val, ctrl_reg} !== '0) begin
            $display("FAIL reset_values got rdy=%0b vld=%0b dz=%0b err=%0b q=%h r=%h loc=%h val=%h ctrl=%h required all 0",
                     req_ready, resp_valid, dz, err, quotient, remainder, in_loc, in_val, ctrl_reg);
            n_fail++;
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL idle_ready req_ready=%0b required 1", req_ready);
            n_fail++;
        end
    endtask

    task automatic test_one(input string name, input logic [63:0] a, input logic [63:0] b,
                            input bit record_lat);
        logic [128:0] e;
        int lat;
        e = ref_div(a, b);
        send_req(a, b, 1'b0);
        wait_resp(lat);
        n_checks++;
        if ({quotient, remainder, dz, err} !== {e, 1'b0}) begin
            $display("FAIL %s_result q=%h r=%h dz=%0b err=%0b required q=%h r=%h dz=%0b err=0",
                     name, quotient, remainder, dz, err, e[128:65], e[64:1], e[0]);
            n_fail++;
        end
        if (record_lat) begin
            lat_ref = lat;
        end else begin
            n_checks++;
            if (lat !== lat_ref) begin
                $display("FAIL %s_latency got %0d required %0d", name, lat, lat_ref);
                n_fail++;
            end
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            $display("FAIL %s_ready_in_resp req_ready=%0b required 0", name, req_ready);
            n_fail++;
        end
        take_resp();
        n_checks++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL %s_resp_drop resp_valid=%0b required 0", name, resp_valid);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        logic [128:0] e;
        int lat;
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            case (i % 4)
                0:       b = {$urandom, $urandom};
                1:       b = 64'($urandom_range(255, 1));
                2:       begin a = 64'($urandom); b = {$urandom | 32'h8000_0000, $urandom}; end
                default: b = (i == 7) ? 64'd0 : {32'd0, $urandom};
            endcase
            e = ref_div(a, b);
            send_req(a, b, 1'b0);
            // Odd iterations raise resp_ready long before the response exists.
            if (i % 2 == 1) resp_ready = 1'b1;
            wait_resp(lat);
            n_checks++;
            if ({quotient, remainder, dz, err} !== {e, 1'b0}) begin
                $display("FAIL rand%0d_result a=%h b=%h q=%h r=%h dz=%0b err=%0b required q=%h r=%h dz=%0b err=0",
                         i, a, b, quotient, remainder, dz, err, e[128:65], e[64:1], e[0]);
                n_fail++;
            end
            n_checks++;
            if (lat !== lat_ref) begin
                $display("FAIL rand%0d_latency got %0d required %0d", i, lat, lat_ref);
                n_fail++;
            end
            take_resp();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] av [3];
        logic [63:0] bv [3];
        logic [128:0] e;
        logic [130:0] snap;
        int lat;
        av = '{64'd1000000007, 64'hDEAD_BEEF_0123_4567, 64'd77};
        bv = '{64'd97, 64'h1_0000, 64'd78};
        for (int i = 0; i < 3; i++) begin
            e = ref_div(av[i], bv[i]);
            send_req(av[i], bv[i], 1'b1);
            if (i < 2) begin
                dividend = av[i + 1];
                divisor  = bv[i + 1];
            end else begin
                req_valid = 1'b0;
            end
            wait_resp(lat);
            if (i == 1) begin
                snap = {resp_valid, req_ready, quotient, remainder, dz};
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if ({resp_valid, req_ready, quotient, remainder, dz} !== snap) begin
                        $display("FAIL b2b_stall%0d vld=%0b rdy=%0b q=%h r=%h required vld=1 rdy=0 q=%h r=%h",
                                 s, resp_valid, req_ready, quotient, remainder, snap[128:65], snap[64:1]);
                        n_fail++;
                    end
                end
            end
            n_checks++;
            if ({quotient, remainder, dz, err, req_ready} !== {e, 2'b00}) begin
                $display("FAIL b2b%0d_result q=%h r=%h err=%0b rdy=%0b required q=%h r=%h err=0 rdy=0",
                         i, quotient, remainder, err, req_ready, e[128:65], e[64:1]);
                n_fail++;
            end
            take_resp();
        end
    endtask

    task automatic test_reset_mid();
        send_req(64'd123456789, 64'd7, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (ctrl_reg !== 32'd1) begin
            $display("FAIL midwait_ctrl ctrl_reg=%h required 1", ctrl_reg);
            n_fail++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({req_ready, resp_valid, dz, err, quotient, remainder, in_loc, in_val, ctrl_reg} !== '0) begin
            $display("FAIL midreset_values rdy=%0b vld=%0b q=%h r=%h loc=%h ctrl=%h required all 0",
                     req_ready, resp_valid, quotient, remainder, in_loc, ctrl_reg);
            n_fail++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_one("after_reset_9_3", 64'd9, 64'd3, 1'b0);
    endtask

    task automatic test_timeout();
        int lat;
        use_stub = 1'b1;
        send_req(64'd50, 64'd5, 1'b0);
        wait_resp(lat);
        n_checks++;
        if ({quotient, remainder, dz, err} !== {128'd0, 1'b0, 1'b1}) begin
            $display("FAIL timeout_result q=%h r=%h dz=%0b err=%0b required q=0 r=0 dz=0 err=1",
                     quotient, remainder, dz, err);
            n_fail++;
        end
        n_checks++;
        if (lat < TMO || lat > TMO + 20) begin
            $display("FAIL timeout_latency got %0d required %0d..%0d", lat, TMO, TMO + 20);
            n_fail++;
        end
        take_resp();
        @(posedge clk); #1;
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            $display("FAIL timeout_idle rdy=%0b vld=%0b required rdy=1 vld=0", req_ready, resp_valid);
            n_fail++;
        end
        use_stub = 1'b0;
        test_one("post_timeout", 64'd1000, 64'd10, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one("div_100_7", 64'd100, 64'd7, 1'b1);
        test_one("wide", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 1'b0);
        test_one("div_zero", 64'd12345, 64'd0, 1'b0);
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
